// File: rtl/clk_mon_pkg.sv
// Shared types and default parameters for the divided-clock monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int DEF_HALF    = 2;
  localparam int DEF_TOL     = 0;
  localparam int DEF_LOCK_N  = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/clk_div_monitor_if.sv
// Status bundle between the clock monitor and the debug/LED logic.
interface clk_div_monitor_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] hi_len;
  logic [CNT_W-1:0] lo_len;
  logic             upd;
  logic             upd_hi;
  logic             locked;
  logic             err_freq;
  logic             err_stuck;
  logic             clr_err;

  modport master (
    output hi_len, lo_len, upd, upd_hi, locked, err_freq, err_stuck,
    input  clr_err
  );

  modport slave (
    input  hi_len, lo_len, upd, upd_hi, locked, err_freq, err_stuck,
    output clr_err
  );
endinterface

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit, async active-low reset.
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low phases of the divided CPU clock and flags lock,
// off-frequency and stuck conditions.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int HALF    = DEF_HALF,
  parameter int TOL     = DEF_TOL,
  parameter int LOCK_N  = DEF_LOCK_N,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpuclk_in,
  clk_div_monitor_if.master  mon
);
  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W+1:0] HALF_C    = (CNT_W+2)'(HALF);
  localparam logic [CNT_W+1:0] TOL_C     = (CNT_W+2)'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LOCK_C    = GW'(LOCK_N);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [GW-1:0]    good_q, good_d;
  logic [CNT_W-1:0] hi_len_q, hi_len_d, lo_len_q, lo_len_d;
  logic             upd_q, upd_d, upd_hi_q, upd_hi_d;
  logic             err_freq_q, err_freq_d, err_stuck_q, err_stuck_d;
  logic             s2, s3_q, s3_d;
  logic             rise, fall, cap, set_freq, set_stuck;
  logic [CNT_W+1:0] len_w;

  bit_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cpuclk_in),
    .q   (s2)
  );

  always_comb begin
    s3_d      = s2;
    rise      = s2 & ~s3_q;
    fall      = ~s2 & s3_q;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    state_d   = state_q;
    cnt_d     = cnt_inc;
    good_d    = good_q;
    hi_len_d  = hi_len_q;
    lo_len_d  = lo_len_q;
    upd_d     = 1'b0;
    upd_hi_d  = upd_hi_q;
    cap       = 1'b0;
    set_freq  = 1'b0;
    set_stuck = 1'b0;
    len_w     = {2'b00, cnt_q};

    case (state_q)
      SEEK: begin
        // partial phase seen here is only used to start timing
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_W'(1);
        end else if (fall) begin
          state_d = LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          hi_len_d = cnt_q;
          upd_d    = 1'b1;
          upd_hi_d = 1'b1;
          cap      = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          lo_len_d = cnt_q;
          upd_d    = 1'b1;
          upd_hi_d = 1'b0;
          cap      = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = HIGH;
        end
      end
      default: state_d = SEEK;
    endcase

    if (cap) begin
      // lower bound written as L+TOL >= HALF so it cannot underflow
      if ((len_w + TOL_C >= HALF_C) && (len_w <= HALF_C + TOL_C)) begin
        good_d = (good_q == LOCK_C) ? good_q : good_q + 1'b1;
      end else begin
        good_d   = '0;
        set_freq = 1'b1;
      end
    end

    if (!(rise || fall) && (cnt_q == TIMEOUT_C)) begin
      state_d   = SEEK;
      cnt_d     = '0;
      good_d    = '0;
      set_stuck = 1'b1;
    end

    err_freq_d  = set_freq  | (err_freq_q  & ~mon.clr_err);
    err_stuck_d = set_stuck | (err_stuck_q & ~mon.clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEEK;
      cnt_q       <= '0;
      good_q      <= '0;
      hi_len_q    <= '0;
      lo_len_q    <= '0;
      upd_q       <= 1'b0;
      upd_hi_q    <= 1'b0;
      err_freq_q  <= 1'b0;
      err_stuck_q <= 1'b0;
      s3_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      good_q      <= good_d;
      hi_len_q    <= hi_len_d;
      lo_len_q    <= lo_len_d;
      upd_q       <= upd_d;
      upd_hi_q    <= upd_hi_d;
      err_freq_q  <= err_freq_d;
      err_stuck_q <= err_stuck_d;
      s3_q        <= s3_d;
    end
  end

  assign mon.hi_len    = hi_len_q;
  assign mon.lo_len    = lo_len_q;
  assign mon.upd       = upd_q;
  assign mon.upd_hi    = upd_hi_q;
  assign mon.locked    = (good_q == LOCK_C);
  assign mon.err_freq  = err_freq_q;
  assign mon.err_stuck = err_stuck_q;
endmodule
